// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control unit for the simple CPU. Fetches one 16-bit instruction
//   at a time over a req/valid handshake, presents the register-file read
//   addresses, evaluates a 4-bit ALU operation and writes the result back.
//   Sequence per instruction: FETCH (waits for instr_valid) -> EXEC -> WB.
//
// Ports
//   clk, reset          clock (posedge) and synchronous active-high reset
//   start               pulse; leaves IDLE or HALT and begins fetching at pc=0
//   instr_req/addr      fetch request (held until instr_valid) and address (pc)
//   instr_valid/data    fetched instruction: op[15:13] rd[12:10] rs1[9:7]
//                       rs2[6:4] imm[3:0]
//   rf_read_address1/2  register-file read addresses (ir.rs1 / ir.rs2)
//   rf_read_data1/2     combinational register-file read data
//   rf_write_address    ir.rd
//   rf_write_data       registered ALU/LDI result
//   rf_write_enable     one-cycle pulse in WB for LDI/ADD/SUB/AND/OR
//   zero_flag           result==0 of the last ALU/LDI write
//   carry_flag          carry of the last ADD / borrow of the last SUB
//   busy, halted        state is neither IDLE nor HALT / state is HALT
//   retired             saturating count of completed instructions
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int PC_WIDTH    = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   instr_req,
    output logic [PC_WIDTH-1:0]    instr_addr,
    input  logic                   instr_valid,
    input  logic [15:0]            instr_data,
    output logic [2:0]             rf_read_address1,
    output logic [2:0]             rf_read_address2,
    input  logic [3:0]             rf_read_data1,
    input  logic [3:0]             rf_read_data2,
    output logic [2:0]             rf_write_address,
    output logic [3:0]             rf_write_data,
    output logic                   rf_write_enable,
    output logic                   zero_flag,
    output logic                   carry_flag,
    output logic                   busy,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_BEQZ = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    state_t                 state_q,   state_d;
    logic [PC_WIDTH-1:0]    pc_q,      pc_d;
    logic [15:0]            ir_q,      ir_d;
    logic [3:0]             result_q,  result_d;
    logic                   zero_q,    zero_d;
    logic                   carry_q,   carry_d;
    logic                   take_q,    take_d;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;

    // Instruction fields, taken from the latched instruction register.
    logic [2:0] ir_op;
    logic [2:0] ir_rd;
    logic [2:0] ir_rs1;
    logic [2:0] ir_rs2;
    logic [3:0] ir_imm;
    logic       ir_writes;

    assign ir_op     = ir_q[15:13];
    assign ir_rd     = ir_q[12:10];
    assign ir_rs1    = ir_q[9:7];
    assign ir_rs2    = ir_q[6:4];
    assign ir_imm    = ir_q[3:0];
    assign ir_writes = (ir_op == OP_LDI) || (ir_op == OP_ADD) || (ir_op == OP_SUB) ||
                       (ir_op == OP_AND) || (ir_op == OP_OR);

    // 5-bit sum/difference: bit 4 is the ADD carry, or the SUB borrow
    // (the difference wraps negative exactly when rs1 < rs2).
    logic [4:0] alu_sum;
    logic [4:0] alu_diff;

    assign alu_sum  = {1'b0, rf_read_data1} + {1'b0, rf_read_data2};
    assign alu_diff = {1'b0, rf_read_data1} - {1'b0, rf_read_data2};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            take_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            take_q    <= take_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        take_d    = take_q;
        retired_d = retired_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end

            ST_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_data;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                take_d = 1'b0;
                case (ir_op)
                    OP_LDI: begin
                        result_d = ir_imm;
                        zero_d   = (ir_imm == 4'd0);
                    end
                    OP_ADD: begin
                        result_d = alu_sum[3:0];
                        zero_d   = (alu_sum[3:0] == 4'd0);
                        carry_d  = alu_sum[4];
                    end
                    OP_SUB: begin
                        result_d = alu_diff[3:0];
                        zero_d   = (alu_diff[3:0] == 4'd0);
                        carry_d  = alu_diff[4];
                    end
                    OP_AND: begin
                        result_d = rf_read_data1 & rf_read_data2;
                        zero_d   = ((rf_read_data1 & rf_read_data2) == 4'd0);
                    end
                    OP_OR: begin
                        result_d = rf_read_data1 | rf_read_data2;
                        zero_d   = ((rf_read_data1 | rf_read_data2) == 4'd0);
                    end
                    // Branch decision is captured here so WB does not depend
                    // on the register file still presenting the same data.
                    OP_BEQZ: take_d = (rf_read_data1 == 4'd0);
                    default: ;
                endcase
                state_d = ST_WB;
            end

            ST_WB: begin
                if (retired_q != {COUNT_WIDTH{1'b1}}) begin
                    retired_d = retired_q + 1'b1;
                end
                if (ir_op == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = take_q ? PC_WIDTH'(ir_imm) : pc_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign instr_req        = (state_q == ST_FETCH);
    assign instr_addr       = pc_q;
    assign rf_read_address1 = ir_rs1;
    assign rf_read_address2 = ir_rs2;
    assign rf_write_address = ir_rd;
    assign rf_write_data    = result_q;
    assign rf_write_enable  = (state_q == ST_WB) && ir_writes;
    assign zero_flag        = zero_q;
    assign carry_flag       = carry_q;
    assign busy             = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted           = (state_q == ST_HALT);
    assign retired          = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//   Self-checking bench for cpu_sequencer. A small register file lives in the
//   bench; an instruction-level reference model (register array, pc, flags,
//   retired count) predicts each write-back and the state after each
//   instruction.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic        instr_req;
    logic [3:0]  instr_addr;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [2:0]  ra1, ra2, wa;
    logic [3:0]  rd1, rd2, wd;
    logic        rf_write_enable, zero_flag, carry_flag, busy, halted;
    logic [7:0]  retired;

    cpu_sequencer #(.PC_WIDTH(4), .COUNT_WIDTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .instr_req        (instr_req),
        .instr_addr       (instr_addr),
        .instr_valid      (instr_valid),
        .instr_data       (instr_data),
        .rf_read_address1 (ra1),
        .rf_read_address2 (ra2),
        .rf_read_data1    (rd1),
        .rf_read_data2    (rd2),
        .rf_write_address (wa),
        .rf_write_data    (wd),
        .rf_write_enable  (rf_write_enable),
        .zero_flag        (zero_flag),
        .carry_flag       (carry_flag),
        .busy             (busy),
        .halted           (halted),
        .retired          (retired)
    );

    // Environment register file: combinational reads, write on clock edge.
    logic [3:0] tb_rf [8];
    logic       rf_clear;
    assign rd1 = tb_rf[ra1];
    assign rd2 = tb_rf[ra2];
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 8; i++) tb_rf[i] <= 4'd0;
        end else if (rf_write_enable) begin
            tb_rf[wa] <= wd;
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int m_rf [8];
    int m_pc, m_zero, m_carry, m_retired, m_halted;

    function automatic logic [15:0] mk(input int op, input int rd, input int rs1,
                                       input int rs2, input int imm);
        return {3'(op), 3'(rd), 3'(rs1), 3'(rs2), 4'(imm)};
    endfunction

    task automatic do_reset();
        reset = 1'b1; rf_clear = 1'b1; start = 1'b0; instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; rf_clear = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
        m_pc = 0; m_zero = 0; m_carry = 0; m_retired = 0; m_halted = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_pc = 0; m_halted = 0;
    endtask

    // Runs one instruction from FETCH through WB and checks every stage
    // against the reference model. Entry and exit are 1 time unit after an edge.
    task automatic exec_instr(input logic [15:0] instr, input int wait_cycles);
        int op, rd, rs1, rs2, imm, a, b, r, exp_we, next_pc;
        op = int'(instr[15:13]); rd = int'(instr[12:10]); rs1 = int'(instr[9:7]);
        rs2 = int'(instr[6:4]); imm = int'(instr[3:0]);

        tests_run++;
        if (instr_req !== 1'b1 || instr_addr !== 4'(m_pc)) begin
            tests_failed++;
            $display("FAIL fetch_req: req=%0b addr=%0d, expected req=1 addr=%0d",
                     instr_req, instr_addr, m_pc);
        end
        for (int i = 0; i < wait_cycles; i++) begin
            instr_data = 16'($urandom);
            @(posedge clk);
            #1;
            tests_run++;
            if (instr_req !== 1'b1 || instr_addr !== 4'(m_pc) || busy !== 1'b1 ||
                rf_write_enable !== 1'b0) begin
                tests_failed++;
                $display("FAIL fetch_wait: req=%0b addr=%0d busy=%0b we=%0b, expected 1/%0d/1/0",
                         instr_req, instr_addr, busy, rf_write_enable, m_pc);
            end
        end

        instr_valid = 1'b1; instr_data = instr;
        @(posedge clk);
        #1;
        // Noise on the fetch port outside FETCH must be ignored.
        instr_valid = 1'($urandom_range(0, 1)); instr_data = 16'($urandom);
        tests_run++;
        if (instr_req !== 1'b0 || rf_write_enable !== 1'b0 ||
            ra1 !== 3'(rs1) || ra2 !== 3'(rs2)) begin
            tests_failed++;
            $display("FAIL exec: req=%0b we=%0b ra1=%0d ra2=%0d, expected 0/0/%0d/%0d",
                     instr_req, rf_write_enable, ra1, ra2, rs1, rs2);
        end

        a = m_rf[rs1]; b = m_rf[rs2]; r = 0; exp_we = 0;
        next_pc = (m_pc + 1) % 16;
        case (op)
            1: begin r = imm; exp_we = 1; m_zero = (r == 0); end
            2: begin r = a + b; m_carry = (r > 15); r = r % 16; exp_we = 1; m_zero = (r == 0); end
            3: begin m_carry = (a < b); r = (a - b + 16) % 16; exp_we = 1; m_zero = (r == 0); end
            4: begin r = a & b; exp_we = 1; m_zero = (r == 0); end
            5: begin r = a | b; exp_we = 1; m_zero = (r == 0); end
            6: if (a == 0) next_pc = imm;
            7: next_pc = m_pc;
            default: ;
        endcase

        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        tests_run++;
        if (rf_write_enable !== 1'(exp_we) ||
            (exp_we == 1 && (wa !== 3'(rd) || wd !== 4'(r)))) begin
            tests_failed++;
            $display("FAIL writeback op=%0d: we=%0b addr=%0d data=%0d, expected we=%0d addr=%0d data=%0d",
                     op, rf_write_enable, wa, wd, exp_we, rd, r);
        end
        if (exp_we == 1) m_rf[rd] = r;
        m_pc = next_pc;
        if (m_retired < 255) m_retired++;
        if (op == 7) m_halted = 1;

        @(posedge clk);
        #1;
        tests_run++;
        if (instr_addr !== 4'(m_pc) || zero_flag !== 1'(m_zero) ||
            carry_flag !== 1'(m_carry) || retired !== 8'(m_retired) ||
            halted !== 1'(m_halted) || busy !== 1'(!m_halted) ||
            instr_req !== 1'(!m_halted) || rf_write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL post op=%0d: addr=%0d z=%0b c=%0b ret=%0d halt=%0b busy=%0b req=%0b we=%0b, expected addr=%0d z=%0d c=%0d ret=%0d halt=%0d",
                     op, instr_addr, zero_flag, carry_flag, retired, halted, busy,
                     instr_req, rf_write_enable, m_pc, m_zero, m_carry, m_retired, m_halted);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (instr_req !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || rf_write_enable !== 1'b0 ||
            instr_addr !== 4'd0 || retired !== 8'd0 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: req=%0b busy=%0b halt=%0b we=%0b addr=%0d ret=%0d z=%0b c=%0b, expected all 0",
                     instr_req, busy, halted, rf_write_enable, instr_addr, retired, zero_flag, carry_flag);
        end
        // instr_valid in IDLE does nothing.
        instr_valid = 1'b1; instr_data = mk(1, 1, 0, 0, 5);
        repeat (2) @(posedge clk);
        #1;
        instr_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || instr_req !== 1'b0 || retired !== 8'd0) begin
            tests_failed++;
            $display("FAIL idle_ignore: busy=%0b req=%0b ret=%0d, expected 0/0/0", busy, instr_req, retired);
        end
        // Reset mid-FETCH after some progress.
        do_start();
        exec_instr(mk(1, 2, 0, 0, 0), 0);
        exec_instr(mk(1, 1, 0, 0, 7), 1);
        do_reset();
        tests_run++;
        if (instr_req !== 1'b0 || busy !== 1'b0 || rf_write_enable !== 1'b0 ||
            instr_addr !== 4'd0 || retired !== 8'd0 || zero_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_fetch: req=%0b busy=%0b we=%0b addr=%0d ret=%0d z=%0b, expected all 0",
                     instr_req, busy, rf_write_enable, instr_addr, retired, zero_flag);
        end
    endtask

    task automatic test_ldi();
        do_reset();
        do_start();
        exec_instr(mk(1, 1, 0, 0, 5), 0);
        tests_run++;
        if (tb_rf[1] !== 4'd5 || zero_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL ldi_r1: r1=%0d z=%0b, expected 5/0", tb_rf[1], zero_flag);
        end
    endtask

    task automatic test_alu();
        do_reset();
        do_start();
        exec_instr(mk(1, 1, 0, 0, 9), 0);
        exec_instr(mk(1, 2, 0, 0, 9), 0);
        exec_instr(mk(2, 3, 1, 2, 0), 0);
        tests_run++;
        if (tb_rf[3] !== 4'd2 || carry_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_carry: r3=%0d c=%0b, expected 2/1", tb_rf[3], carry_flag);
        end
        exec_instr(mk(3, 4, 3, 1, 0), 0);
        tests_run++;
        if (tb_rf[4] !== 4'd9 || carry_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_borrow: r4=%0d c=%0b, expected 9/1", tb_rf[4], carry_flag);
        end
        exec_instr(mk(4, 5, 1, 3, 0), 0);   // 9 & 2 = 0 -> zero set
        exec_instr(mk(5, 6, 1, 3, 0), 0);   // 9 | 2 = 11
        exec_instr(mk(2, 1, 1, 1, 0), 0);   // rs==rd: 9+9 -> r1=2
    endtask

    task automatic test_beqz();
        do_reset();
        do_start();
        exec_instr(mk(6, 0, 0, 0, 12), 0);
        tests_run++;
        if (instr_addr !== 4'd12) begin
            tests_failed++;
            $display("FAIL beqz_taken: addr=%0d, expected 12", instr_addr);
        end
        exec_instr(mk(1, 1, 0, 0, 5), 0);
        exec_instr(mk(6, 0, 1, 0, 3), 0);
        tests_run++;
        if (instr_addr !== 4'd14) begin
            tests_failed++;
            $display("FAIL beqz_not_taken: addr=%0d, expected 14", instr_addr);
        end
    endtask

    task automatic test_fetch_wait();
        do_reset();
        do_start();
        exec_instr(mk(1, 3, 0, 0, 4), 4);
        exec_instr(mk(0, 0, 0, 0, 0), 2);
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_start();
        exec_instr(mk(1, 1, 0, 0, 3), 0);
        exec_instr(mk(1, 2, 0, 0, 6), 0);
        // start while busy must not move the pc back to 0.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tests_run++;
        if (instr_addr !== 4'd2 || instr_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_busy: addr=%0d req=%0b, expected 2/1", instr_addr, instr_req);
        end
        exec_instr(mk(2, 7, 1, 2, 0), 0);
    endtask

    task automatic test_halt();
        do_reset();
        do_start();
        exec_instr(mk(6, 0, 0, 0, 15), 0);
        exec_instr(mk(7, 0, 0, 0, 0), 0);
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (halted !== 1'b1 || busy !== 1'b0 || retired !== 8'd2 || instr_addr !== 4'd15) begin
            tests_failed++;
            $display("FAIL halt_hold: halt=%0b busy=%0b ret=%0d addr=%0d, expected 1/0/2/15",
                     halted, busy, retired, instr_addr);
        end
        do_start();
        tests_run++;
        if (instr_addr !== 4'd0 || busy !== 1'b1 || retired !== 8'd2) begin
            tests_failed++;
            $display("FAIL halt_restart: addr=%0d busy=%0b ret=%0d, expected 0/1/2", instr_addr, busy, retired);
        end
        exec_instr(mk(6, 0, 0, 0, 15), 0);
        exec_instr(mk(0, 0, 0, 0, 0), 0);
        tests_run++;
        if (instr_addr !== 4'd0) begin
            tests_failed++;
            $display("FAIL pc_wrap: addr=%0d, expected 0", instr_addr);
        end
    endtask

    task automatic test_random();
        logic [15:0] instr;
        do_reset();
        do_start();
        for (int n = 0; n < 300; n++) begin
            instr = 16'($urandom);
            if (instr[15:13] == 3'd7 && $urandom_range(0, 3) != 0)
                instr[15:13] = 3'($urandom_range(0, 6));
            exec_instr(instr, $urandom_range(0, 3));
            if (m_halted == 1) begin
                do_start();
                tests_run++;
                if (instr_addr !== 4'd0 || instr_req !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL random_restart: addr=%0d req=%0b, expected 0/1", instr_addr, instr_req);
                end
            end
        end
        tests_run++;
        if (retired !== 8'hFF) begin
            tests_failed++;
            $display("FAIL retired_saturate: ret=%0d, expected 255", retired);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; instr_valid = 1'b0; instr_data = 16'd0; rf_clear = 1'b1;
        test_reset();
        test_ldi();
        test_alu();
        test_beqz();
        test_fetch_wait();
        test_back_to_back();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
